// File: rtl/apb_conv_pkg.sv
// apb_conv_pkg: shared APB transfer states, grant encoding and default timeout
package apb_conv_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} apb_state_e;
  typedef enum logic {GNT_READ = 1'b0, GNT_WRITE = 1'b1} apb_grant_e;
  localparam int APB_TIMEOUT_DEFAULT = 256;
endpackage

// File: rtl/apb_req_slot.sv
// apb_req_slot: one-entry request hold register; a start while occupied is ignored
module apb_req_slot #(
  parameter int W = 8
) (
  input  logic         axi_clk,
  input  logic         sys_aresetn,
  input  logic         start,
  input  logic         clear,
  input  logic [W-1:0] req,
  output logic         valid,
  output logic [W-1:0] held
);
  always_ff @(posedge axi_clk or negedge sys_aresetn)
    if (!sys_aresetn) begin
      valid <= 1'b0;
      held  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (start && !valid) begin
      valid <= 1'b1;
      held  <= req;
    end
endmodule

// File: rtl/apb_txn_sequencer.sv
// apb_txn_sequencer: arbitrates one pending write and one pending read onto an APB master port
module apb_txn_sequencer
  import apb_conv_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DEFAULT
) (
  input  logic            axi_clk,
  input  logic            sys_aresetn,
  input  logic            start_write,
  input  logic [AW-1:0]   write_address,
  input  logic [DW-1:0]   write_data,
  input  logic [DW/8-1:0] be,
  input  logic [2:0]      wprot,
  input  logic            start_read,
  input  logic [AW-1:0]   read_address,
  input  logic [2:0]      rprot,
  output logic            done_write,
  output logic [DW-1:0]   read_data,
  output logic            read_data_valid,
  output logic            slv_err,
  output logic [AW-1:0]   paddr,
  output logic            psel,
  output logic            penable,
  output logic            pwrite,
  output logic [DW-1:0]   pwdata,
  output logic [DW/8-1:0] pstrb,
  output logic [2:0]      pprot,
  input  logic [DW-1:0]   prdata,
  input  logic            pready,
  input  logic            pslverr
);
  localparam int SW = DW / 8;
  localparam int WW = AW + DW + SW + 3;
  localparam int RW = AW + 3;
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  apb_state_e state, state_n;
  apb_grant_e last_grant, grant;
  logic wv, rv, tie, fin, expired;
  logic [WW-1:0] wreq;
  logic [RW-1:0] rreq;
  logic [CW-1:0] cnt;
  apb_req_slot #(.W(WW)) u_wslot (
    .axi_clk     (axi_clk),
    .sys_aresetn (sys_aresetn),
    .start       (start_write),
    .clear       (fin && pwrite),
    .req         ({write_address, write_data, be, wprot}),
    .valid       (wv),
    .held        (wreq)
  );
  apb_req_slot #(.W(RW)) u_rslot (
    .axi_clk     (axi_clk),
    .sys_aresetn (sys_aresetn),
    .start       (start_read),
    .clear       (fin && !pwrite),
    .req         ({read_address, rprot}),
    .valid       (rv),
    .held        (rreq)
  );
  always_comb begin
    tie     = wv && rv;
    grant   = tie ? (last_grant == GNT_READ ? GNT_WRITE : GNT_READ) : (wv ? GNT_WRITE : GNT_READ);
    expired = state == ACCESS && !pready && TIMEOUT_CYCLES != 0 && cnt == CW'(TIMEOUT_CYCLES - 1);
    fin     = state == ACCESS && (pready || expired);
    state_n = state == IDLE ? (wv || rv ? SETUP : IDLE) :
              state == SETUP ? ACCESS :
              state == ACCESS && !fin ? ACCESS : IDLE;
    psel    = state == SETUP || state == ACCESS;
    penable = state == ACCESS;
  end
  always_ff @(posedge axi_clk or negedge sys_aresetn)
    if (!sys_aresetn) state <= IDLE;
    else state <= state_n;
  // last_grant only moves on a genuine tie, so lone requests do not disturb alternation
  always_ff @(posedge axi_clk or negedge sys_aresetn)
    if (!sys_aresetn) begin
      last_grant      <= GNT_READ;
      cnt             <= '0;
      pwrite          <= 1'b0;
      paddr           <= '0;
      pwdata          <= '0;
      pstrb           <= '0;
      pprot           <= '0;
      done_write      <= 1'b0;
      read_data_valid <= 1'b0;
      read_data       <= '0;
      slv_err         <= 1'b0;
    end else begin
      cnt             <= state == ACCESS && !fin ? cnt + 1'b1 : '0;
      done_write      <= fin && pwrite;
      read_data_valid <= fin && !pwrite;
      if (fin) slv_err <= !pready || pslverr;
      if (fin && !pwrite) read_data <= pready ? prdata : '0;
      if (state == IDLE && (wv || rv)) begin
        if (tie) last_grant <= grant;
        pwrite <= grant == GNT_WRITE;
        if (grant == GNT_WRITE) {paddr, pwdata, pstrb, pprot} <= wreq;
        else begin
          {paddr, pprot} <= rreq;
          pstrb <= '0;
        end
      end
    end
endmodule

// File: doc/apb_txn_sequencer.md
APB_TXN_SEQUENCER -- requirements
Module: apb_txn_sequencer

Interface
- REQ-001 SHALL have parameter AW, default 32, address width.
- REQ-002 SHALL have parameter DW, default 32, data width (multiple of 8).
- REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, ACCESS-cycle limit; 0 disables timeout.
- REQ-004 SHALL have one clock and an asynchronous active-low reset:
  - axi_clk  in  1  sole clock
  - sys_aresetn  in  1  asynchronous, active-low reset
- REQ-005 SHALL have these write request ports:
  - start_write  in  1  one-cycle write request pulse
  - write_address  in  AW  write address
  - write_data  in  DW  write data
  - be  in  DW/8  byte enables
  - wprot  in  3  write protection
- REQ-006 SHALL have these read request ports:
  - start_read  in  1  one-cycle read request pulse
  - read_address  in  AW  read address
  - rprot  in  3  read protection
- REQ-007 SHALL have these completion ports:
  - done_write  out  1  write-completion pulse
  - read_data  out  DW  read data
  - read_data_valid  out  1  read-completion pulse
  - slv_err  out  1  completion status
- REQ-008 SHALL have these APB master ports:
  - paddr  out  AW
  - psel  out  1
  - penable  out  1
  - pwrite  out  1
  - pwdata  out  DW
  - pstrb  out  DW/8
  - pprot  out  3
  - prdata  in  DW
  - pready  in  1
  - pslverr  in  1

Function
- REQ-009 SHALL hold one pending slot per direction; the slot is captured on a start pulse and cleared when that transfer completes.
- REQ-010 SHALL ignore a start pulse arriving while its slot is occupied; the held request is unchanged.
- REQ-011 SHALL run FSM IDLE -> SETUP -> ACCESS -> IDLE; IDLE leaves only when at least one slot is valid.
- REQ-012 SHALL, with both slots valid in IDLE, grant the direction opposite to last_grant; last_grant resets to read, so write wins the first tie.
- REQ-013 SHALL drive SETUP as psel=1, penable=0, and ACCESS as psel=1, penable=1.
  - paddr, pwrite, pwdata, pstrb and pprot are loaded on IDLE->SETUP and stay stable through ACCESS.
- REQ-014 SHALL drive pstrb=0 for reads.
- REQ-015 SHALL, in IDLE, drive psel=0 and penable=0; the other APB outputs hold their last values.
- REQ-016 SHALL stay in ACCESS until pready=1, then return to IDLE.
- REQ-017 SHALL take the following cycle-level timing, with start pulse sampled at edge N and pready=1 in the first ACCESS cycle:
  - slot valid after N+1
  - SETUP after N+2
  - ACCESS after N+3
  - completion pulse and IDLE after N+4
- REQ-018 SHALL spend at least one IDLE cycle between consecutive transfers.
- REQ-019 SHALL count ACCESS cycles with a counter wide enough for TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES without pready: terminate the transfer, complete with slv_err=1, return read_data=0, drop psel/penable.
- REQ-020 SHALL, on completion, pulse done_write (write) or read_data_valid (read) for exactly one cycle.
  - slv_err takes pslverr (or 1 on timeout) and holds until the next completion.
  - read_data takes prdata on a read completion only.
- REQ-021 SHALL capture a start pulse that coincides with a completion or grant of the other direction; no request is lost.

Reset
- REQ-022 SHALL, on sys_aresetn low, immediately clear the following outputs to 0: psel, penable, pwrite, paddr, pwdata, pstrb, pprot, done_write, read_data_valid, read_data, slv_err.
  - It also clears both slots, sets FSM to IDLE, resets last_grant to read and zeroes the timeout counter.
- REQ-023 SHALL, on reset mid-transfer, abandon the transfer without a completion pulse; reset deassertion resumes from IDLE.

Structure
- REQ-024 SHALL take the state enum typedef (IDLE, SETUP, ACCESS) and the grant encoding from shared package apb_conv_pkg.
- REQ-025 SHALL take the default timeout constant from apb_conv_pkg.
- REQ-026 SHALL implement the pending slot as sub-module apb_req_slot (one-entry hold register with valid), instantiated once per direction.

Verification
- REQ-027 Write 0x0000_0010/0xDEAD_BEEF, be=0xF, pready=1 immediately -> one SETUP and one ACCESS cycle with pstrb=0xF, then done_write at N+4 with slv_err=0.
- REQ-028 Read 0x0000_0020, prdata=0x1234_5678, pready after 3 wait cycles -> read_data_valid one cycle, read_data=0x1234_5678, penable high for 4 cycles.
- REQ-029 start_write and start_read in the same cycle -> write completes first, read next; a second simultaneous pair is ordered read then write.
- REQ-030 TIMEOUT_CYCLES=8, pready held low -> termination after 8 ACCESS cycles with slv_err=1 and read_data=0; FSM returns to IDLE.
- REQ-031 pslverr=1 on a write -> done_write with slv_err=1; a following clean read -> slv_err=0.
- REQ-032 sys_aresetn low during ACCESS -> psel/penable low without waiting for a clock edge, no completion pulse, and a fresh request after release completes normally.
